// File: rtl/tdm_demux_pkg.sv
// Shared constants for the TDM demultiplexer: FSM state encodings and N_CH limits.
package tdm_demux_pkg;

  localparam int unsigned N_CH_MIN = 2;
  localparam int unsigned N_CH_MAX = 16;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE    = 1'b0;
  localparam logic [STATE_W-1:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/tdm_demux_if.sv
// Word-stream input and frame output bundle of the TDM demultiplexer.
interface tdm_demux_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);

  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic [N_CH*W-1:0] out_data;
  logic              out_valid;
  logic              frame_err;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, frame_err
  );

endinterface

// File: rtl/tdm_slot_bank.sv
// N_CH x W staging registers: one write port, every word visible on a flat read vector.
module tdm_slot_bank #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [$clog2(N_CH)-1:0]   waddr,
  input  logic [W-1:0]              wdata,
  output logic [N_CH*W-1:0]         rd_flat
);

  logic [W-1:0] stage_q [N_CH];
  logic [W-1:0] stage_d [N_CH];

  always_comb begin
    stage_d = stage_q;
    if (we) stage_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '{default: '0};
    else        stage_q <= stage_d;
  end

  always_comb begin
    rd_flat = '0;
    for (int unsigned k = 0; k < N_CH; k++) rd_flat[k*W +: W] = stage_q[k];
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: gathers N_CH successive slot words into one wide frame,
// publishing it with a one-cycle strobe and flagging orphan words and early SOFs.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int unsigned SLOT_W = $clog2(N_CH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("tdm_demux: N_CH out of legal range");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [N_CH*W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               bank_we_c;
  logic [SLOT_W-1:0]  bank_waddr_c;
  logic [N_CH*W-1:0]  bank_flat;
  logic [N_CH*W-1:0]  frame_c;

  tdm_slot_bank #(.N_CH(N_CH), .W(W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we_c),
    .waddr   (bank_waddr_c),
    .wdata   (bus.in_data),
    .rd_flat (bank_flat)
  );

  // Published frame is the bank plus the last-slot word arriving this cycle.
  always_comb begin
    frame_c = bank_flat;
    frame_c[(N_CH-1)*W +: W] = bus.in_data;
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_err_d  = 1'b0;
    bank_we_c    = 1'b0;
    bank_waddr_c = slot_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_sof) begin
            bank_we_c    = 1'b1;
            bank_waddr_c = '0;
            slot_d       = SLOT_ONE;
            state_d      = ST_COLLECT;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.in_valid) begin
          bank_we_c = 1'b1;
          if (bus.in_sof) begin
            // Early SOF restarts the frame; stale slots get rewritten before publish.
            frame_err_d  = 1'b1;
            bank_waddr_c = '0;
            slot_d       = SLOT_ONE;
          end else if (slot_q == SLOT_LAST) begin
            out_data_d   = frame_c;
            out_valid_d  = 1'b1;
            slot_d       = '0;
            state_d      = ST_IDLE;
          end else begin
            slot_d       = slot_q + SLOT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic against a queue model.
module tb_tdm_demux;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 8;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: words of the current frame in a queue, expected outputs after the coming edge.
  logic [W-1:0]      mq[$];
  logic [N_CH*W-1:0] m_data;
  bit                m_valid;
  bit                m_err;

  function automatic void model_step(input bit v, input bit s, input logic [W-1:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (s) begin
        if (mq.size() != 0) m_err = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        mq.push_back(d);
        if (mq.size() == N_CH) begin
          for (int k = 0; k < N_CH; k++) m_data[k*W +: W] = mq[k];
          m_valid = 1'b1;
          mq.delete();
        end
      end
    end
  endfunction

  // Apply one cycle of input at the falling edge; outputs are settled #1 after the rising edge.
  task automatic cycle(input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    mq.delete();
    m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got valid=%b err=%b want 0/0", bus.out_valid, bus.frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cycle(1'b1, i == 0, d[i]);
      else       cycle(1'b0, 1'b0, 8'hEE);
      pulses += int'(bus.out_valid);
      checks++;
      if (bus.out_valid !== m_valid || bus.frame_err !== m_err || bus.out_data !== m_data) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", i,
                 bus.out_valid, bus.frame_err, bus.out_data, m_valid, m_err, m_data);
      end
      if (i == 3) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
          errors++; $display("FAIL basic_publish: got v=%b d=%h want 1 44332211", bus.out_valid, bus.out_data);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL basic_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int pulses = 0;
    int errs   = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i == 0, d[i]);
      pulses += int'(bus.out_valid);
      errs   += int'(bus.frame_err);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 1'b1, 8'hFF);
          pulses += int'(bus.out_valid);
          errs   += int'(bus.frame_err);
        end
      end
    end
    cycle(1'b0, 1'b0, 8'h00);
    pulses += int'(bus.out_valid);
    checks++;
    if (pulses != 1 || errs != 0 || bus.out_data !== 32'h44332211) begin
      errors++;
      $display("FAIL gapped: got pulses=%0d errs=%0d d=%h want 1 0 44332211", pulses, errs, bus.out_data);
    end
  endtask

  task automatic test_early_sof();
    logic [W-1:0] d[6] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    bit           s[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int errs = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, s[i], d[i]);
      errs += int'(bus.frame_err);
      checks++;
      if (bus.out_valid !== m_valid || bus.frame_err !== m_err || bus.out_data !== m_data) begin
        errors++;
        $display("FAIL early_sof[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", i,
                 bus.out_valid, bus.frame_err, bus.out_data, m_valid, m_err, m_data);
      end
      if (i == 2) begin
        checks++;
        if (bus.frame_err !== 1'b1 || bus.out_data !== 32'h44332211) begin
          errors++; $display("FAIL early_sof_err: got e=%b d=%h want 1 44332211", bus.frame_err, bus.out_data);
        end
      end
    end
    checks++;
    if (errs != 1 || bus.out_data !== 32'hB4B3B2B1) begin
      errors++; $display("FAIL early_sof_final: got errs=%0d d=%h want 1 b4b3b2b1", errs, bus.out_data);
    end
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_orphan();
    logic [W-1:0] d[4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    cycle(1'b1, 1'b0, 8'h55);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'hB4B3B2B1) begin
      errors++;
      $display("FAIL orphan: got e=%b v=%b d=%h want 1 0 b4b3b2b1", bus.frame_err, bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, d[i]);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.out_data !== 32'hC4C3C2C1) begin
      errors++;
      $display("FAIL orphan_recover: got v=%b e=%b d=%h want 1 0 c4c3c2c1", bus.out_valid, bus.frame_err, bus.out_data);
    end
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    int p_cyc[$];
    logic [N_CH*W-1:0] p_dat[$];
    for (int i = 0; i < 9; i++) begin
      if (i < 8) cycle(1'b1, (i % 4) == 0, d[i]);
      else       cycle(1'b0, 1'b0, 8'h00);
      if (bus.out_valid === 1'b1) begin
        p_cyc.push_back(cyc);
        p_dat.push_back(bus.out_data);
      end
      checks++;
      if (bus.frame_err !== 1'b0 || bus.out_valid !== m_valid) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b e=%b want v=%b e=0", i, bus.out_valid, bus.frame_err, m_valid);
      end
    end
    checks++;
    if (p_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 2", p_cyc.size());
    end else begin
      checks++;
      if (p_cyc[1] - p_cyc[0] != 4 || p_dat[0] !== 32'h04030201 || p_dat[1] !== 32'h08070605) begin
        errors++;
        $display("FAIL b2b_frames: got gap=%0d d0=%h d1=%h want 4 04030201 08070605",
                 p_cyc[1] - p_cyc[0], p_dat[0], p_dat[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d[4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    cycle(1'b1, 1'b1, 8'hE1);
    cycle(1'b1, 1'b0, 8'hE2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    m_data = '0;
    #1;
    checks++;
    if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got d=%h v=%b e=%b want 0 0 0", bus.out_data, bus.out_valid, bus.frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i == 0, d[i]);
      checks++;
      if (bus.frame_err !== 1'b0 || bus.out_valid !== m_valid || bus.out_data !== m_data) begin
        errors++;
        $display("FAIL mid_reset_frame[%0d]: got v=%b e=%b d=%h want v=%b e=0 d=%h", i,
                 bus.out_valid, bus.frame_err, bus.out_data, m_valid, m_data);
      end
    end
    checks++;
    if (bus.out_data !== 32'hD4D3D2D1) begin
      errors++; $display("FAIL mid_reset_publish: got %h want d4d3d2d1", bus.out_data);
    end
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    bit v, s;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (mq.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      d = W'($urandom);
      cycle(v, s, d);
      checks++;
      if (bus.out_valid !== m_valid || bus.frame_err !== m_err || bus.out_data !== m_data) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h", i,
                 bus.out_valid, bus.frame_err, bus.out_data, m_valid, m_err, m_data);
      end
    end
  endtask

  initial begin
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_early_sof();
    test_orphan();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
